// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants and FSM state type
// for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_PASS   = 4'b0010;
    localparam logic [3:0] ALU_NOT    = 4'b0011;
    localparam logic [3:0] ALU_AND    = 4'b0100;
    localparam logic [3:0] ALU_OR     = 4'b0101;
    localparam logic [3:0] ALU_NAND   = 4'b0110;
    localparam logic [3:0] ALU_NOR    = 4'b0111;
    localparam logic [3:0] ALU_XOR    = 4'b1000;
    localparam logic [3:0] ALU_XNOR   = 4'b1001;
    localparam logic [3:0] ALU_SHL_NE = 4'b1010;
    localparam logic [3:0] ALU_SHR_GE = 4'b1011;
    localparam logic [3:0] ALU_SHL    = 4'b1100;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_NEG    = 4'b1110;
    localparam logic [3:0] ALU_ZERO   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU with branch-condition flag,
// shared by both requesters of alu_arbiter.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_bcond
);

    always_comb begin
        o_result = '0;
        o_bcond  = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result = i_a + i_b;
                o_bcond  = (i_a == i_b);
            end
            ALU_SUB:  o_result = i_a - i_b;
            ALU_PASS: o_result = i_a;
            ALU_NOT:  o_result = ~i_a;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_NAND: o_result = ~(i_a & i_b);
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_XOR: begin
                o_result = i_a ^ i_b;
                o_bcond  = (i_a < i_b);
            end
            ALU_XNOR: o_result = ~(i_a ^ i_b);
            ALU_SHL_NE: begin
                o_result = {i_a[30:0], 1'b0};
                o_bcond  = (i_a != i_b);
            end
            ALU_SHR_GE: begin
                o_result = {1'b0, i_a[31:1]};
                o_bcond  = (i_a >= i_b);
            end
            ALU_SHL:  o_result = {i_a[30:0], 1'b0};
            ALU_SRA:  o_result = {i_a[31], i_a[31:1]};
            ALU_NEG:  o_result = (~i_a) + 32'd1;
            ALU_ZERO: o_result = '0;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter letting two requesters share one ALU,
// with a single operation in flight (IDLE -> EXEC -> RESP).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_RESET_PRIO = 1'b0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_bcond,
    output logic        busy,
    output logic [15:0] op_count
);

    state_e      r_state;
    logic        r_run;
    logic        r_last;
    logic        r_gnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic        r_bcond;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [15:0] r_op_count;

    logic        w_idle;
    logic        w_both;
    logic        w_any;
    logic        w_sel;
    logic        w_acc;
    logic        w_rsp_hs;
    logic [31:0] w_alu_result;
    logic        w_alu_bcond;

    // r_run keeps ready low until the first edge after reset release
    assign w_idle = r_run && (r_state == ST_IDLE);
    assign w_both = req0_valid & req1_valid;
    assign w_any  = req0_valid | req1_valid;
    assign w_sel  = w_both ? ~r_last : req1_valid;
    assign w_acc  = w_idle & w_any;

    assign req0_ready = w_acc & ~w_sel;
    assign req1_ready = w_acc & w_sel;

    assign w_rsp_hs = (r_rsp0_valid & rsp0_ready)
                    | (r_rsp1_valid & rsp1_ready);

    alu_arbiter_alu u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_bcond  (w_alu_bcond)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_run        <= 1'b0;
            r_last       <= ~RR_RESET_PRIO;
            r_gnt        <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_bcond      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_gnt   <= w_sel;
                        r_op    <= w_sel ? req1_op : req0_op;
                        r_a     <= w_sel ? req1_a  : req0_a;
                        r_b     <= w_sel ? req1_b  : req0_b;
                        r_state <= ST_EXEC;
                        if (w_both)
                            r_last <= w_sel;
                    end
                end
                ST_EXEC: begin
                    r_result     <= w_alu_result;
                    r_bcond      <= w_alu_bcond;
                    r_rsp0_valid <= ~r_gnt;
                    r_rsp1_valid <= r_gnt;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_result     <= '0;
                        r_bcond      <= 1'b0;
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_op_count   <= r_op_count + 16'd1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_result = r_result;
    assign rsp_bcond  = r_bcond;
    assign busy       = (r_state != ST_IDLE);
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: opcode table, arbitration,
// back-pressure, reset during EXEC and op_count wrap.
module tb_alu_arbiter;

    typedef struct {
        logic        idx;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bc;
    } vec_t;

    typedef struct {
        logic        idx;
        logic [31:0] res;
        logic        bc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_bcond;
    logic        busy;
    logic [15:0] op_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;
    exp_t        q[$];
    vec_t        tbl[19];

    alu_arbiter #(.RR_RESET_PRIO(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_bcond  (rsp_bcond),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input logic idx);
        return idx ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input logic idx);
        return idx ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic present(input logic idx, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic bc);
        exp_t e;
        if (idx) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        e.idx = idx; e.res = res; e.bc = bc;
        q.push_back(e);
    endtask

    task automatic accept(input logic idx);
        int n = 0;
        #1;
        while (!rdy(idx) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, n < 20}, 32'd1);
        @(posedge clk);
        #1;
        if (idx) req1_valid = 1'b0;
        else     req0_valid = 1'b0;
    endtask

    task automatic respond(input int hold);
        exp_t e;
        int   edges = 1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = q.pop_front();
        @(negedge clk);
        while (!rspv(e.idx) && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", edges, 32'd2);
        chk("rsp_other_valid", {31'd0, rspv(~e.idx)}, 32'd0);
        chk("result", rsp_result, e.res);
        chk("bcond", {31'd0, rsp_bcond}, {31'd0, e.bc});
        for (int k = 0; k < hold; k++) begin
            if (e.idx) req0_valid = 1'b1;
            else       req1_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_result", rsp_result, e.res);
            chk("hold_valid", {31'd0, rspv(e.idx)}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd1);
            chk("hold_no_accept", {31'd0, rdy(~e.idx)}, 32'd0);
        end
        if (hold > 0) begin
            if (e.idx) req0_valid = 1'b0;
            else       req1_valid = 1'b0;
        end
        if (e.idx) rsp1_ready = 1'b1;
        else       rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        chk("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_result_zero", rsp_result, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b0000, 32'd5,        32'd5,        32'd10,       1'b1};
        tbl[1]  = '{1'b1, 4'b0001, 32'd10,       32'd3,        32'd7,        1'b0};
        tbl[2]  = '{1'b0, 4'b0010, 32'h12345678, 32'd9,        32'h12345678, 1'b0};
        tbl[3]  = '{1'b1, 4'b0011, 32'h0,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[4]  = '{1'b0, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        tbl[5]  = '{1'b1, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0};
        tbl[7]  = '{1'b1, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
        tbl[8]  = '{1'b0, 4'b1000, 32'd3,        32'd7,        32'd4,        1'b1};
        tbl[9]  = '{1'b1, 4'b1001, 32'd3,        32'd7,        32'hFFFFFFFB, 1'b0};
        tbl[10] = '{1'b0, 4'b1010, 32'h40000001, 32'd1,        32'h80000002, 1'b1};
        tbl[11] = '{1'b1, 4'b1011, 32'd3,        32'd7,        32'd1,        1'b0};
        tbl[12] = '{1'b0, 4'b1011, 32'd7,        32'd3,        32'd3,        1'b1};
        tbl[13] = '{1'b1, 4'b1100, 32'h80000001, 32'd0,        32'h00000002, 1'b0};
        tbl[14] = '{1'b0, 4'b1101, 32'h80000000, 32'd0,        32'hC0000000, 1'b0};
        tbl[15] = '{1'b1, 4'b1110, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[16] = '{1'b0, 4'b1111, 32'hDEADBEEF, 32'd1,        32'd0,        1'b0};
        tbl[17] = '{1'b1, 4'b0000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        tbl[18] = '{1'b0, 4'b1000, 32'd7,        32'd3,        32'd4,        1'b0};

        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        #3;
        chk("rst_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("release_ready_low", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // contended start: req0 first, then req1 with no extra gap
        present(1'b0, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0);
        present(1'b1, 4'b0001, 32'd9, 32'd4, 32'd5, 1'b0);
        #1;
        chk("contend0_r0", {31'd0, req0_ready}, 32'd1);
        chk("contend0_r1", {31'd0, req1_ready}, 32'd0);
        accept(1'b0);
        respond(0);
        chk("no_gap_r1", {31'd0, req1_ready}, 32'd1);
        accept(1'b1);
        respond(0);

        // second contention goes to req1
        present(1'b1, 4'b0010, 32'hAA, 32'd0, 32'hAA, 1'b0);
        present(1'b0, 4'b0011, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0);
        #1;
        chk("contend1_r1", {31'd0, req1_ready}, 32'd1);
        chk("contend1_r0", {31'd0, req0_ready}, 32'd0);
        accept(1'b1);
        respond(0);
        accept(1'b0);
        respond(0);

        for (int i = 0; i < 19; i++) begin
            present(tbl[i].idx, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].bc);
            accept(tbl[i].idx);
            respond(0);
        end

        // back-pressure on requester 1 while requester 0 waits
        present(1'b1, 4'b1101, 32'h80000000, 32'd0, 32'hC0000000, 1'b0);
        accept(1'b1);
        respond(3);

        // reset during EXEC discards the operation
        present(1'b0, 4'b0000, 32'd5, 32'd5, 32'd10, 1'b1);
        accept(1'b0);
        void'(q.pop_front());
        #1;
        chk("exec_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_exec_busy", {31'd0, busy}, 32'd0);
        chk("rst_exec_count", {16'd0, op_count}, 32'd0);
        chk("rst_exec_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("rst_exec_result", rsp_result, 32'd0);
        exp_cnt = 16'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        end

        // op_count wrap from a forced value
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        @(negedge clk);
        chk("preload", {16'd0, op_count}, 32'h0000FFFF);
        exp_cnt = 16'hFFFF;
        present(1'b0, 4'b0000, 32'd5, 32'd5, 32'd10, 1'b1);
        accept(1'b0);
        respond(0);
        chk("wrap", {16'd0, op_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_RESET_PRIO, default 0, meaning the requester (0 or 1) that wins the first contended grant after reset.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  operation request from requester 0 / 1.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  request accepted this cycle when ready and valid are both 1.
REQ-006 The block SHALL have ports req0_op / req1_op  input  4  ALU opcode.
REQ-007 The block SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-008 The block SHALL have ports rsp0_valid / rsp1_valid  output  1  result available for requester 0 / 1.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready  input  1  requester consumes the result.
REQ-010 The block SHALL have port rsp_result  output  32  and port rsp_bcond  output  1, shared by both response channels.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port op_count  output  16  number of completed response handshakes.

Function
REQ-013 The block SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE, one shared ALU, and at most one operation in flight.
REQ-014 In IDLE, the block SHALL assert reqN_ready combinationally only for the granted requester: the sole valid one, or, if both are valid, the one not granted last.
REQ-015 When a request handshake occurs, the block SHALL latch op, a, b and the grant index, and move to EXEC.
REQ-016 In EXEC, the block SHALL drive the ALU from the latched registers, register result and bcond at the clock edge, and move to RESP.
REQ-017 In RESP, the block SHALL assert rspN_valid for the latched grant index only.
REQ-018 In RESP, rsp_result and rsp_bcond SHALL hold stable until rspN_ready is 1; on that edge the FSM returns to IDLE and op_count increments.
REQ-019 Latency SHALL be fixed: a request accepted at edge N gives rsp valid from edge N+2, with a minimum of 3 cycles per operation.
REQ-020 No request SHALL be accepted in EXEC or RESP, and req*_ready SHALL be 0 in those states.
REQ-021 ALU semantics SHALL be as follows:
- 0000 add, bcond = (a==b)
- 0001 sub
- 0010 pass a
- 0011 not a
- 0100/0101/0110/0111 and/or/nand/nor
- 1000 xor, bcond = unsigned (a<b)
- 1001 xnor
- 1010 a<<1, bcond = (a!=b)
- 1011 logical a>>1, bcond = unsigned (a>=b)
- 1100 a<<1
- 1101 arithmetic a>>1
- 1110 two's-complement negate
- 1111 result 0
- bcond = 0 for every other opcode
REQ-022 op_count SHALL wrap from 16'hFFFF to 0 with no flag.
REQ-023 The round-robin pointer SHALL update only on a request handshake, and only when the request is contended.
REQ-024 rsp_result and rsp_bcond SHALL be 0 whenever the block is not in RESP.

Reset
REQ-025 Reset SHALL force all of the following immediately, independent of clk:
- state IDLE
- all rsp*_valid and req*_ready 0 until the first edge after release
- rsp_result 0, rsp_bcond 0
- busy 0
- op_count 0
- last grant = 1 - RR_RESET_PRIO
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is issued afterwards.

Structure
REQ-027 A shared package SHALL hold the 4-bit opcode constants (ALU_ADD ... ALU_ZERO) and the FSM state enum.
REQ-028 The ALU SHALL be a single instantiated combinational sub-module, ALU; the arbiter contains no arithmetic of its own.

Verification
REQ-029 Directed test: req0 op=0000 a=5 b=5 -> rsp0_valid two edges later, result 10, bcond 1, op_count 1.
REQ-030 Directed test: req0 and req1 both valid right after reset with RR_RESET_PRIO=0 -> req0 is served first and req1 second, with no idle gap beyond IDLE.
REQ-031 Directed test: req1 op=1101 a=32'h80000000 with rsp1_ready held 0 for 3 cycles -> result stays 32'hC0000000, busy stays 1, and req0 is not accepted.
REQ-032 Directed test: op=1000 a=3 b=7 -> result 4, bcond 1; op=1011 a=3 b=7 -> result 1, bcond 0.
REQ-033 Directed test: op_count preloaded to 16'hFFFF by 65535 ops (or a forced value), then one more response -> op_count reads 0.
REQ-034 Directed test: reset asserted during EXEC -> outputs clear at once, and no rsp*_valid appears after release until a new request.
